edge_event_arbiter: RTL

- Multi-channel edge-event controller. Detects rising and falling edges on N_CH synchronous level inputs and holds each detected edge as a sticky pending request.
- Round-robin arbitration serialises the pending requests onto a single registered valid/ready event channel, with channel ID and edge polarity.
- Sits between per-signal edge detection and the interrupt/event consumer, so one consumer services every monitored line.

---
 rtl/edge_event_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/edge_event_arbiter.sv
// rtl/edge_event_arbiter.sv - per-channel edge capture with round-robin event serialiser
module edge_event_arbiter #(
    parameter int N_CH = 4,
    parameter int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] a_i,
    input  logic [N_CH-1:0] rise_en_i,
    input  logic [N_CH-1:0] fall_en_i,
    output logic            evt_valid_o,
    input  logic            evt_ready_i,
    output logic [CH_W-1:0] evt_ch_o,
    output logic            evt_rise_o,
    output logic [N_CH-1:0] ovf_o,
    input  logic [N_CH-1:0] ovf_clr_i,
    output logic            busy_o
);
    localparam int NS = 2 * N_CH;
    localparam int SW = $clog2(NS);
    localparam logic [SW:0] NS_W = (SW + 1)'(NS);

    logic [N_CH-1:0]   a_f_q, a_f_d;
    logic [N_CH-1:0]   ovf_q, ovf_d, ovf_set;
    logic [NS-1:0]     pend_q, pend_d, det, grant;
    logic [SW-1:0]     rr_q, rr_d, win, off;
    logic [SW:0]       sum, rr_nxt;
    logic [2*NS-1:0]   pend_dbl;
    logic [NS-1:0]     rot;
    logic              found, load;
    logic              valid_q, valid_d, rise_q, rise_d;
    logic [CH_W-1:0]   ch_q, ch_d;

    // Source 2*i is channel i rising, 2*i+1 is channel i falling.
    always_comb begin
        det = '0;
        for (int i = 0; i < N_CH; i++) begin
            det[2*i]   = a_i[i] & ~a_f_q[i] & rise_en_i[i];
            det[2*i+1] = ~a_i[i] & a_f_q[i] & fall_en_i[i];
        end
    end

    // Rotate pending bits so rr_q sits at bit 0; the lowest set bit is the winner's offset.
    always_comb begin
        pend_dbl = {pend_q, pend_q} >> rr_q;
        rot      = pend_dbl[NS-1:0];
        found    = |rot;
        off      = '0;
        for (int k = NS - 1; k >= 0; k--) begin
            if (rot[k]) begin
                off = SW'(k);
            end
        end
        sum = {1'b0, rr_q} + {1'b0, off};
        if (sum >= NS_W) begin
            sum = sum - NS_W;
        end
        win    = sum[SW-1:0];
        rr_nxt = {1'b0, win} + 1'b1;
        if (rr_nxt == NS_W) begin
            rr_nxt = '0;
        end
    end

    always_comb begin
        load    = ~valid_q | evt_ready_i;
        grant   = '0;
        valid_d = valid_q;
        ch_d    = ch_q;
        rise_d  = rise_q;
        rr_d    = rr_q;
        if (load) begin
            valid_d = found;
            if (found) begin
                grant[win] = 1'b1;
                ch_d       = CH_W'(win >> 1);
                rise_d     = ~win[0];
                rr_d       = rr_nxt[SW-1:0];
            end
        end
        // A source being loaded this cycle can take a fresh detection without loss.
        pend_d  = det | (pend_q & ~grant);
        ovf_set = '0;
        for (int i = 0; i < N_CH; i++) begin
            ovf_set[i] = (det[2*i]   & pend_q[2*i]   & ~grant[2*i]) |
                         (det[2*i+1] & pend_q[2*i+1] & ~grant[2*i+1]);
        end
        ovf_d = (ovf_q & ~ovf_clr_i) | ovf_set;
        a_f_d = a_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_f_q   <= '0;
            pend_q  <= '0;
            ovf_q   <= '0;
            valid_q <= 1'b0;
            ch_q    <= '0;
            rise_q  <= 1'b0;
            rr_q    <= '0;
        end else begin
            a_f_q   <= a_f_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            ch_q    <= ch_d;
            rise_q  <= rise_d;
            rr_q    <= rr_d;
        end
    end

    assign evt_valid_o = valid_q;
    assign evt_ch_o    = ch_q;
    assign evt_rise_o  = rise_q;
    assign ovf_o       = ovf_q;
    assign busy_o      = (|pend_q) | valid_q;

endmodule
